// File: rtl/bp_table_write_scheduler_if.sv
// bp_table_write_scheduler_if: request, grant and table-write signals of the write scheduler
interface bp_table_write_scheduler_if #(
  parameter int INDEX_WIDTH = 10,
  parameter int DATA_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
);
  logic rec_valid;
  logic [INDEX_WIDTH-1:0] rec_index;
  logic [DATA_WIDTH-1:0] rec_data;
  logic upd_valid;
  logic [INDEX_WIDTH-1:0] upd_index;
  logic [DATA_WIDTH-1:0] upd_data;
  logic upd_ready;
  logic spec_valid;
  logic [INDEX_WIDTH-1:0] spec_index;
  logic [DATA_WIDTH-1:0] spec_data;
  logic spec_grant;
  logic wr_en;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [DATA_WIDTH-1:0] wr_data;
  logic init_busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0] drop_count;
  modport slave (
    input rec_valid, rec_index, rec_data, upd_valid, upd_index, upd_data,
          spec_valid, spec_index, spec_data,
    output upd_ready, spec_grant, wr_en, wr_index, wr_data, init_busy, fifo_level, drop_count
  );
  modport master (
    output rec_valid, rec_index, rec_data, upd_valid, upd_index, upd_data,
           spec_valid, spec_index, spec_data,
    input upd_ready, spec_grant, wr_en, wr_index, wr_data, init_busy, fifo_level, drop_count
  );
endinterface

// File: rtl/bp_table_write_scheduler.sv
// bp_table_write_scheduler: arbitrates recovery, deferred-update and speculative writes onto one table write port
module bp_table_write_scheduler #(
  parameter int ENTRY_NUM = 1024,
  parameter int INDEX_WIDTH = 10,
  parameter int DATA_WIDTH = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int INIT_VALUE = 0
) (
  input logic clk,
  input logic rst,
  bp_table_write_scheduler_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {INIT, RUN} stateT;
  stateT state;
  logic [INDEX_WIDTH-1:0] sweep;
  logic [INDEX_WIDTH-1:0] qIndex [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] qData [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr, tailPtr;
  logic [PW:0] level;
  logic [15:0] drops;
  logic wrEn;
  logic [INDEX_WIDTH-1:0] wrIndex;
  logic [DATA_WIDTH-1:0] wrData;
  logic run, empty, deq, specGrant, updReady, accept, coalesce, push;
  // Grant decisions for this cycle; the tail may only absorb an update if it is not leaving the FIFO now
  always_comb begin
    run = state == RUN;
    empty = level == '0;
    tailPtr = wrPtr + {PW{1'b1}};
    deq = run && !bus.rec_valid && !empty;
    specGrant = run && bus.spec_valid && !bus.rec_valid && empty;
    updReady = run && level < (PW+1)'(FIFO_DEPTH);
    accept = bus.upd_valid && updReady;
    coalesce = accept && !empty && qIndex[tailPtr] == bus.upd_index && !(deq && level == (PW+1)'(1));
    push = accept && !coalesce;
  end
  // Init sweep / run arbitration state, registered write port and deferred-update FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      level <= '0;
      drops <= '0;
      wrEn <= 1'b0;
    end else begin
      if (!run) begin
        wrEn <= 1'b1;
        wrIndex <= sweep;
        wrData <= DATA_WIDTH'(INIT_VALUE);
        sweep <= sweep + 1'b1;
        if (sweep == INDEX_WIDTH'(ENTRY_NUM - 1)) state <= RUN;
      end else begin
        wrEn <= bus.rec_valid || deq || specGrant;
        if (bus.rec_valid) begin
          wrIndex <= bus.rec_index;
          wrData <= bus.rec_data;
        end else if (deq) begin
          wrIndex <= qIndex[rdPtr];
          wrData <= qData[rdPtr];
        end else if (specGrant) begin
          wrIndex <= bus.spec_index;
          wrData <= bus.spec_data;
        end
        if (bus.spec_valid && !specGrant && drops != 16'hFFFF) drops <= drops + 1'b1;
      end
      if (deq) rdPtr <= rdPtr + 1'b1;
      if (push) begin
        qIndex[wrPtr] <= bus.upd_index;
        qData[wrPtr] <= bus.upd_data;
        wrPtr <= wrPtr + 1'b1;
      end
      if (coalesce) qData[tailPtr] <= bus.upd_data;
      level <= level + (PW+1)'(push) - (PW+1)'(deq);
    end
  end
  assign bus.upd_ready = updReady;
  assign bus.spec_grant = specGrant;
  assign bus.wr_en = wrEn;
  assign bus.wr_index = wrIndex;
  assign bus.wr_data = wrData;
  assign bus.init_busy = !run;
  assign bus.fifo_level = level;
  assign bus.drop_count = drops;
endmodule

// File: tb/tb_bp_table_write_scheduler.sv
// tb_bp_table_write_scheduler: directed and random checks against a queue-based reference model
module tb_bp_table_write_scheduler;
  localparam int ENTRIES = 16;
  localparam int DEPTH = 4;
  localparam int INITV = 8'h3C;
  typedef struct {int idx; int data;} entT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bit mInit = 1'b1;
  int mSweep = 0;
  int mDrops = 0;
  entT q[$];
  bit eWrEn = 1'b0;
  bit wrKnown = 1'b0;
  int eIdx = 0;
  int eData = 0;
  bp_table_write_scheduler_if #(.INDEX_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) bus();
  bp_table_write_scheduler #(.ENTRY_NUM(ENTRIES), .INDEX_WIDTH(4), .DATA_WIDTH(8),
    .FIFO_DEPTH(DEPTH), .INIT_VALUE(INITV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic model();
    bit popHead;
    entT head;
    if (rst) begin
      mInit = 1'b1;
      mSweep = 0;
      q.delete();
      mDrops = 0;
      eWrEn = 1'b0;
    end else if (mInit) begin
      eWrEn = 1'b1;
      eIdx = mSweep;
      eData = INITV;
      wrKnown = 1'b1;
      mSweep++;
      if (mSweep == ENTRIES) mInit = 1'b0;
    end else begin
      popHead = !bus.rec_valid && q.size() > 0;
      eWrEn = 1'b1;
      if (bus.rec_valid) begin
        eIdx = bus.rec_index;
        eData = bus.rec_data;
      end else if (popHead) begin
        head = q[0];
        eIdx = head.idx;
        eData = head.data;
      end else if (bus.spec_valid) begin
        eIdx = bus.spec_index;
        eData = bus.spec_data;
      end else eWrEn = 1'b0;
      if (eWrEn) wrKnown = 1'b1;
      if (bus.spec_valid && (bus.rec_valid || q.size() > 0) && mDrops < 65535) mDrops++;
      if (bus.upd_valid && q.size() < DEPTH) begin
        if (q.size() > 0 && q[q.size()-1].idx == int'(bus.upd_index) && !(popHead && q.size() == 1))
          q[q.size()-1].data = bus.upd_data;
        else
          q.push_back('{int'(bus.upd_index), int'(bus.upd_data)});
      end
      if (popHead) void'(q.pop_front());
    end
  endtask
  task automatic cycle();
    #1;
    chk("init_busy", bus.init_busy, mInit);
    chk("upd_ready", bus.upd_ready, !mInit && q.size() < DEPTH);
    chk("spec_grant", bus.spec_grant, !mInit && bus.spec_valid && !bus.rec_valid && q.size() == 0);
    chk("fifo_level", bus.fifo_level, q.size());
    chk("drop_count", bus.drop_count, mDrops);
    chk("wr_en", bus.wr_en, eWrEn);
    if (wrKnown) begin
      chk("wr_index", bus.wr_index, eIdx);
      chk("wr_data", bus.wr_data, eData);
    end
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  initial begin
    bus.rec_valid = 0; bus.rec_index = 0; bus.rec_data = 0;
    bus.upd_valid = 0; bus.upd_index = 0; bus.upd_data = 0;
    bus.spec_valid = 0; bus.spec_index = 0; bus.spec_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_init_busy", bus.init_busy, 1);
    chk("rst_upd_ready", bus.upd_ready, 0);
    chk("rst_fifo_level", bus.fifo_level, 0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      bus.rec_valid = 1'($urandom); bus.rec_index = 4'($urandom);
      bus.spec_valid = 1'($urandom); bus.upd_valid = 1'($urandom);
      cycle();
      chk("init_wr_en", bus.wr_en, 1);
      chk("init_wr_index", bus.wr_index, i);
      chk("init_wr_data", bus.wr_data, INITV);
      chk("init_busy_fall", bus.init_busy, i < ENTRIES - 1);
      chk("init_upd_ready", bus.upd_ready, i == ENTRIES - 1);
    end
    chk("init_no_drops", bus.drop_count, 0);
    bus.rec_valid = 1; bus.rec_index = 3; bus.rec_data = 8'h2A;
    bus.upd_valid = 1; bus.upd_index = 5; bus.upd_data = 8'h11;
    bus.spec_valid = 1; bus.spec_index = 7; bus.spec_data = 8'h77;
    cycle();
    bus.rec_valid = 0; bus.upd_valid = 0; bus.spec_valid = 0;
    chk("prio_rec_idx", bus.wr_index, 3);
    chk("prio_rec_data", bus.wr_data, 8'h2A);
    chk("prio_drop", bus.drop_count, 1);
    cycle();
    chk("prio_upd_en", bus.wr_en, 1);
    chk("prio_upd_idx", bus.wr_index, 5);
    chk("prio_upd_data", bus.wr_data, 8'h11);
    cycle();
    chk("idle_wr_en", bus.wr_en, 0);
    chk("idle_hold_idx", bus.wr_index, 5);
    bus.rec_valid = 1; bus.rec_index = 0; bus.rec_data = 0;
    for (int k = 1; k <= 4; k++) begin
      bus.upd_valid = 1; bus.upd_index = 4'(k); bus.upd_data = 8'(8'h10 + k);
      cycle();
    end
    bus.upd_index = 5; bus.upd_data = 8'h15;
    #1;
    chk("full_level", bus.fifo_level, 4);
    chk("full_ready", bus.upd_ready, 0);
    bus.rec_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k == 2) bus.upd_valid = 0;
      chk("drain_en", bus.wr_en, 1);
      chk("drain_idx", bus.wr_index, k);
      chk("drain_data", bus.wr_data, 8'h10 + k);
    end
    cycle();
    bus.rec_valid = 1;
    bus.upd_valid = 1; bus.upd_index = 9; bus.upd_data = 8'h01;
    cycle();
    bus.upd_data = 8'h02;
    cycle();
    bus.upd_valid = 0;
    chk("coal_level", bus.fifo_level, 1);
    bus.rec_valid = 0;
    cycle();
    chk("coal_idx", bus.wr_index, 9);
    chk("coal_data", bus.wr_data, 8'h02);
    cycle();
    chk("coal_single", bus.wr_en, 0);
    bus.rec_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      bus.upd_valid = 1; bus.upd_index = 4'(k); bus.upd_data = 8'(k);
      cycle();
    end
    chk("mid_level", bus.fifo_level, 3);
    rst = 1'b1; bus.rec_valid = 0; bus.upd_valid = 0;
    cycle();
    chk("mrst_level", bus.fifo_level, 0);
    chk("mrst_wr_en", bus.wr_en, 0);
    chk("mrst_drops", bus.drop_count, 0);
    chk("mrst_busy", bus.init_busy, 1);
    rst = 1'b0;
    cycle();
    chk("mrst_sweep_en", bus.wr_en, 1);
    chk("mrst_sweep_idx", bus.wr_index, 0);
    repeat (ENTRIES - 1) cycle();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(99) == 0;
      bus.rec_valid = $urandom_range(3) == 0; bus.rec_index = 4'($urandom); bus.rec_data = 8'($urandom);
      bus.upd_valid = 1'($urandom); bus.upd_index = 4'($urandom_range(3)); bus.upd_data = 8'($urandom);
      bus.spec_valid = 1'($urandom); bus.spec_index = 4'($urandom); bus.spec_data = 8'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
